pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer: branch/jump/call/return, a return-address stack,
// halt, and a single-level context exchange with a saved PC.
module pc_sequencer #(
    parameter int ADDR_WIDTH     = 12,
    parameter int RESET_VECTOR   = 256,
    parameter int CONTEXT_VECTOR = 1083,
    parameter int STACK_DEPTH    = 8
) (
    input  logic                         clock,
    input  logic                         resetCPU,
    input  logic [ADDR_WIDTH-1:0]        address,
    input  logic                         zero,
    input  logic                         negative,
    input  logic                         bzero,
    input  logic                         bnegative,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         HLT,
    input  logic                         jump_context_exchange,
    input  logic                         context_return,
    output logic [ADDR_WIDTH-1:0]        programCounter,
    output logic [$clog2(STACK_DEPTH):0] stack_level,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    localparam int IW = $clog2(STACK_DEPTH);
    localparam int LW = IW + 1;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] CONTEXT_PC = ADDR_WIDTH'(CONTEXT_VECTOR);
    localparam logic [LW-1:0]         FULL_LEVEL = LW'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] saved_pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] branch_add;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic [ADDR_WIDTH-1:0] lower_pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [IW-1:0]         top_idx;
    logic [IW-1:0]         push_idx;
    logic                  taken;
    logic                  empty;
    logic                  full;
    logic                  stack_ok;
    logic                  push;
    logic                  pop;
    logic                  set_ovf;
    logic                  set_unf;

    always_comb begin
        pc_inc     = programCounter + 1'b1;
        branch_add = pc_inc + address;
        taken      = (bzero & zero) | (bnegative & negative);
        empty      = (stack_level == '0);
        full       = (stack_level == FULL_LEVEL);
        top_idx    = IW'(stack_level - 1'b1);
        push_idx   = stack_level[IW-1:0];
        stack_top  = stack[top_idx];

        // lower_pc is what the PC would become with both context controls low;
        // it also feeds saved_pc on a context exchange.
        lower_pc = pc_inc;
        if (HLT)
            lower_pc = programCounter;
        else if (ret)
            lower_pc = empty ? pc_inc : stack_top;
        else if (call || jump)
            lower_pc = address;
        else if (taken)
            lower_pc = branch_add;

        stack_ok = !jump_context_exchange && !context_return && !HLT;
        push     = stack_ok && !ret && call && !full;
        set_ovf  = stack_ok && !ret && call && full;
        pop      = stack_ok && ret && !empty;
        set_unf  = stack_ok && ret && empty;

        pc_next = lower_pc;
        if (jump_context_exchange)
            pc_next = CONTEXT_PC;
        else if (context_return)
            pc_next = saved_pc;
    end

    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) begin
            programCounter  <= RESET_PC;
            saved_pc        <= RESET_PC;
            stack_level     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            programCounter <= pc_next;
            if (jump_context_exchange)
                saved_pc <= lower_pc;
            if (push)
                stack_level <= stack_level + 1'b1;
            else if (pop)
                stack_level <= stack_level - 1'b1;
            if (set_ovf)
                stack_overflow <= 1'b1;
            if (set_unf)
                stack_underflow <= 1'b1;
        end
    end

    // Entries are not reset: anything written at or above stack_level is never read.
    always_ff @(posedge clock) begin
        if (push)
            stack[push_idx] <= pc_inc;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes reference-model results,
// a monitor pops and compares one entry after every clock edge.
module tb_pc_sequencer;

    localparam int CZ  = 1;
    localparam int CN  = 2;
    localparam int CBZ = 4;
    localparam int CBN = 8;
    localparam int CJ  = 16;
    localparam int CC  = 32;
    localparam int CR  = 64;
    localparam int CH  = 128;
    localparam int CX  = 256;
    localparam int CCR = 512;

    logic        clock = 1'b0;
    logic        resetCPU;
    logic [11:0] address;
    logic        zero, negative, bzero, bnegative, jump, call, ret, HLT;
    logic        jump_context_exchange, context_return;
    logic [11:0] programCounter;
    logic [3:0]  stack_level;
    logic        stack_overflow, stack_underflow;

    typedef struct {
        logic [11:0] pc;
        int          level;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [11:0] m_pc;
    logic [11:0] m_saved;
    logic [11:0] m_stk[$];
    bit          m_ovf, m_unf;

    pc_sequencer #(
        .ADDR_WIDTH    (12),
        .RESET_VECTOR  (256),
        .CONTEXT_VECTOR(1083),
        .STACK_DEPTH   (8)
    ) dut (
        .clock                (clock),
        .resetCPU             (resetCPU),
        .address              (address),
        .zero                 (zero),
        .negative             (negative),
        .bzero                (bzero),
        .bnegative            (bnegative),
        .jump                 (jump),
        .call                 (call),
        .ret                  (ret),
        .HLT                  (HLT),
        .jump_context_exchange(jump_context_exchange),
        .context_return       (context_return),
        .programCounter       (programCounter),
        .stack_level          (stack_level),
        .stack_overflow       (stack_overflow),
        .stack_underflow      (stack_underflow)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_pc    = 12'd256;
        m_saved = 12'd256;
        m_stk.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_direct(input string name);
        checks++;
        if (programCounter !== m_pc || int'(stack_level) != m_stk.size() ||
            stack_overflow !== m_ovf || stack_underflow !== m_unf) begin
            errors++;
            $display("FAIL %s: got pc=%0d lvl=%0d ovf=%0b unf=%0b, want pc=%0d lvl=%0d ovf=%0b unf=%0b",
                     name, programCounter, stack_level, stack_overflow, stack_underflow,
                     m_pc, m_stk.size(), m_ovf, m_unf);
        end
    endtask

    // Called at a negedge: drive controls, advance the reference model, queue the result.
    task automatic issue(input logic [11:0] a, input int ctl);
        logic [11:0] inc, lower;
        bit          z, n, bz, bn, j, c, r, h, x, cr, tk, emp;
        z  = (ctl & CZ)  != 0;  n  = (ctl & CN)  != 0;
        bz = (ctl & CBZ) != 0;  bn = (ctl & CBN) != 0;
        j  = (ctl & CJ)  != 0;  c  = (ctl & CC)  != 0;
        r  = (ctl & CR)  != 0;  h  = (ctl & CH)  != 0;
        x  = (ctl & CX)  != 0;  cr = (ctl & CCR) != 0;
        address = a; zero = z; negative = n; bzero = bz; bnegative = bn;
        jump = j; call = c; ret = r; HLT = h;
        jump_context_exchange = x; context_return = cr;

        inc = m_pc + 12'd1;
        tk  = (bz && z) || (bn && n);
        emp = (m_stk.size() == 0);
        if (h)           lower = m_pc;
        else if (r)      lower = emp ? inc : m_stk[m_stk.size()-1];
        else if (c || j) lower = a;
        else if (tk)     lower = inc + a;
        else             lower = inc;

        if (x) begin
            m_saved = lower;
            m_pc    = 12'd1083;
        end else if (cr) begin
            m_pc = m_saved;
        end else begin
            if (!h) begin
                if (r) begin
                    if (emp) m_unf = 1'b1;
                    else void'(m_stk.pop_back());
                end else if (c) begin
                    if (m_stk.size() == 8) m_ovf = 1'b1;
                    else m_stk.push_back(inc);
                end
            end
            m_pc = lower;
        end
        sb.push_back('{m_pc, m_stk.size(), m_ovf, m_unf});
        @(negedge clock);
    endtask

    task automatic reset_pulse();
        @(posedge clock);
        #2 resetCPU = 1'b1;
        model_reset();
        #1 check_direct("async_reset_pulse");
        resetCPU = 1'b0;
        @(negedge clock);
    endtask

    task automatic reset_mid_call();
        address = 12'd777; call = 1'b1; HLT = 1'b0; ret = 1'b0; jump = 1'b0;
        jump_context_exchange = 1'b0; context_return = 1'b0;
        #2 resetCPU = 1'b1;
        @(posedge clock);
        #2 resetCPU = 1'b0;
        call = 1'b0;
        model_reset();
        #1 check_direct("reset_mid_call");
        @(negedge clock);
    endtask

    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (programCounter !== e.pc || int'(stack_level) != e.level ||
                stack_overflow !== e.ovf || stack_underflow !== e.unf) begin
                errors++;
                $display("FAIL step@%0t: got pc=%0d lvl=%0d ovf=%0b unf=%0b, want pc=%0d lvl=%0d ovf=%0b unf=%0b",
                         $time, programCounter, stack_level, stack_overflow, stack_underflow,
                         e.pc, e.level, e.ovf, e.unf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ctl;
        resetCPU = 1'b1;
        address = '0; zero = 0; negative = 0; bzero = 0; bnegative = 0;
        jump = 0; call = 0; ret = 0; HLT = 0;
        jump_context_exchange = 0; context_return = 0;
        model_reset();
        @(negedge clock);
        check_direct("reset_state");
        resetCPU = 1'b0;

        // idle after reset: 257, 258, 259
        repeat (3) issue(12'd0, 0);

        // conditional branch taken / not taken
        issue(12'd300, CJ);
        issue(12'd10, CBZ | CZ);
        issue(12'd300, CJ);
        issue(12'd10, CBZ);

        // wrap at 4095 and negative offset
        issue(12'd4095, CJ);
        issue(12'd0, 0);
        issue(12'd4095, CBN | CN);

        // call / ret / underflow
        issue(12'd400, CJ);
        issue(12'd800, CC);
        issue(12'd0, CR);
        issue(12'd0, CR);
        issue(12'd5, CC | CR);
        reset_pulse();

        // nine nested calls then eight LIFO returns
        for (int i = 0; i < 9; i++) issue(12'(100 * i + 37), CC);
        for (int i = 0; i < 8; i++) issue(12'd0, CR);
        issue(12'd9, CC | CJ | CH);

        // halted context exchange and return
        issue(12'd500, CJ);
        issue(12'd0, CH | CX);
        issue(12'd0, CC);
        issue(12'd0, CCR);
        issue(12'd0, CCR | CX | CR);

        reset_mid_call();
        issue(12'd0, 0);

        for (int i = 0; i < 400; i++) begin
            int p;
            ctl = int'($urandom_range(0, 15));
            p = int'($urandom_range(0, 99));
            if (p < 4)       ctl |= CX;
            else if (p < 8)  ctl |= CCR;
            if ($urandom_range(0, 9) == 0) ctl |= CH;
            if ($urandom_range(0, 5) == 0) ctl |= CR;
            if ($urandom_range(0, 3) == 0) ctl |= CC;
            if ($urandom_range(0, 9) == 0) ctl |= CJ;
            issue(12'($urandom), ctl);
            if (i % 60 == 59) reset_pulse();
        end

        issue(12'd0, 0);
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clock);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
